bus_cycle_master: RTL
=====================

# bus_cycle_master

Upstream bus-cycle generator for the 8088-compatible memory/I/O modules. Accepts single-byte read/write requests from an internal valid/ready interface, decodes them into memory or I/O chip selects, and drives 8088-style T1–T4 bus cycles (ALE, RD, WR, ADDRESS, DATA) whose timing exactly matches the slave's IDLE→LOAD_ADDR→READ/WRITE sequence. Read data and a decode-error flag are returned on a one-cycle response strobe.

## Interface
- ADDR_WIDTH, 20, bus address width; DATA_WIDTH, 8, data width
- MEM_BASE, 20'h00000, base of memory window (aligned to 2^MEM_SIZE_LOG2)
- MEM_SIZE_LOG2, 19, log2 bytes in memory window
- IO_BASE, 16'h0300, base of I/O window (aligned to 2^IO_SIZE_LOG2)
- IO_SIZE_LOG2, 4, log2 ports in I/O window
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK
- REQ_VALID  in  1  request present
- REQ_READY  out  1  request accepted on edge where VALID&&READY
- REQ_WR  in  1  1=write, 0=read
- REQ_IO  in  1  1=I/O space, 0=memory space
- REQ_ADDR  in  ADDR_WIDTH  byte address (I/O uses bits [15:0], upper bits driven 0 on bus)
- REQ_WDATA  in  DATA_WIDTH  write data
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  DATA_WIDTH  read data (valid with RSP_VALID on reads)
- RSP_ERR  out  1  access hit neither window
- ALE  out  1  address latch enable, active high
- CS_MEM, CS_IO  out  1 each  chip selects, active high
- RD, WR  out  1 each  strobes, active low
- ADDRESS  out  ADDR_WIDTH  bus address
- DATA  inout  DATA_WIDTH  bidirectional data bus
- READY  in  1  slave ready, sampled end of T3/TW (tie 1 for fixed-timing slaves)

## Operation
- States: IDLE, T1, T2, T3, TW, T4. REQ_READY = (state==IDLE) && !RESET.
- Accept edge: latch REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA into request registers; compute decode; go T1.
- Decode: mem hit = !io && addr[ADDR_WIDTH-1:MEM_SIZE_LOG2]==MEM_BASE[ADDR_WIDTH-1:MEM_SIZE_LOG2]; io hit = io && addr[15:IO_SIZE_LOG2]==IO_BASE[15:IO_SIZE_LOG2]. At most one CS asserted; miss ⇒ no CS, cycle still runs, RSP_ERR=1.
- T1: ALE=1, selected CS=1, ADDRESS valid. → T2.
- T2: ALE=0, CS held, ADDRESS held; RD=0 (read) or WR=0 (write); write drives DATA=WDATA. → T3.
- T3: strobe held, DATA driven on write. READY=1 ⇒ T4; READY=0 ⇒ TW.
- TW: identical outputs to T3; stays while READY=0, → T4 when READY=1.
- Read capture: DATA sampled into RSP_RDATA on the edge leaving T3/TW with READY=1; on miss RSP_RDATA=all ones.
- T4: RD=WR=1, CS held, DATA released (read) / still driven (write); RSP_VALID=1 for this cycle only. → IDLE.
- All bus outputs registered (no combinational path from REQ_* or READY to bus pins).
- DATA driven only from T2 through T4 of a write; Z otherwise, including all of a read.

## Timing
- Reset values: ALE=0, CS_MEM=CS_IO=0, RD=WR=1, ADDRESS=0, DATA=Z, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, REQ_READY=0 during RESET.
- RESET mid-cycle: next edge forces IDLE with reset outputs; no RSP_VALID for aborted request.
- Latency READY=1: accept edge at cycle 0, T1..T4 at cycles 1..4, RSP_VALID at cycle 4; next accept in cycle 5. Throughput 1 access / 5 cycles.
- Each TW adds exactly one cycle to latency and to strobe width.
- Slave alignment: slave sees CS&&ALE in T1, latches address in T2, OE/write in T3; master samples read data end of T3.
- REQ_VALID while not IDLE: ignored, held by requester (no buffering).

## Test plan
- Reset: assert RESET 3 cycles mid-T2 of a read → RD=1, CS=0, DATA=Z, REQ_READY=0, no RSP_VALID; IDLE after release.
- Memory write then read: write 8'hA5 to 20'h01234, read back → ALE only in T1, WR low T2–T3, RSP_RDATA=8'hA5, RSP_ERR=0, RSP_VALID 4 cycles after each accept.
- I/O read: REQ_IO=1, addr 16'h0305 → CS_IO=1 T1–T4, CS_MEM=0, ADDRESS=20'h00305, data from slave returned.
- Decode miss: memory read 20'h80000 → no CS, RSP_ERR=1, RSP_RDATA=8'hFF.
- Wait states: READY=0 for 2 cycles in T3 → RD low 4 cycles, RSP_VALID at cycle 6, data sampled on READY=1 edge.
- Back-to-back: REQ_VALID held with 4 queued requests → accepts exactly every 5 cycles, DATA never driven during reads (no contention).

Source files
------------

// File: rtl/bus_cycle_master_if.sv
// Request/response handshake and 8088-style bus control signals for bus_cycle_master.
// The bidirectional DATA bus is kept as a plain module port.
interface bus_cycle_master_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WR;
  logic                  REQ_IO;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  ALE;
  logic                  CS_MEM;
  logic                  CS_IO;
  logic                  RD;
  logic                  WR;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic                  READY;

  modport master (
    input  REQ_VALID, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA, READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output ALE, CS_MEM, CS_IO, RD, WR, ADDRESS
  );

  modport slave (
    output REQ_VALID, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA, READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  ALE, CS_MEM, CS_IO, RD, WR, ADDRESS
  );
endinterface

// File: rtl/bus_cycle_master.sv
// 8088-style T1..T4 bus-cycle generator: decodes single-byte requests into memory/I/O
// chip selects and returns read data plus a decode-error flag on a one-cycle strobe.
module bus_cycle_master #(
  parameter int                    ADDR_WIDTH    = 20,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE      = 20'h00000,
  parameter int                    MEM_SIZE_LOG2 = 19,
  parameter logic [15:0]           IO_BASE       = 16'h0300,
  parameter int                    IO_SIZE_LOG2  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  bus_cycle_master_if.master    bus,
  inout  wire  [DATA_WIDTH-1:0] DATA
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

  state_t                state_reg;
  logic                  ale_reg;
  logic                  cs_mem_reg;
  logic                  cs_io_reg;
  logic                  rd_reg;
  logic                  wr_reg;
  logic [ADDR_WIDTH-1:0] address_reg;
  logic                  data_oe_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  req_wr_reg;
  logic                  req_miss_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;

  logic mem_hit;
  logic io_hit;

  assign mem_hit = !bus.REQ_IO &&
                   (bus.REQ_ADDR[ADDR_WIDTH-1:MEM_SIZE_LOG2] == MEM_BASE[ADDR_WIDTH-1:MEM_SIZE_LOG2]);
  assign io_hit  = bus.REQ_IO &&
                   (bus.REQ_ADDR[15:IO_SIZE_LOG2] == IO_BASE[15:IO_SIZE_LOG2]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      ale_reg       <= 1'b0;
      cs_mem_reg    <= 1'b0;
      cs_io_reg     <= 1'b0;
      rd_reg        <= 1'b1;
      wr_reg        <= 1'b1;
      address_reg   <= '0;
      data_oe_reg   <= 1'b0;
      wdata_reg     <= '0;
      req_wr_reg    <= 1'b0;
      req_miss_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.REQ_VALID) begin
            req_wr_reg   <= bus.REQ_WR;
            wdata_reg    <= bus.REQ_WDATA;
            req_miss_reg <= !(mem_hit || io_hit);
            ale_reg      <= 1'b1;
            cs_mem_reg   <= mem_hit;
            cs_io_reg    <= io_hit;
            // I/O cycles only carry a 16-bit port number on the bus
            address_reg  <= bus.REQ_IO ? {{(ADDR_WIDTH-16){1'b0}}, bus.REQ_ADDR[15:0]}
                                       : bus.REQ_ADDR;
            state_reg    <= T1;
          end
        end
        T1: begin
          ale_reg     <= 1'b0;
          rd_reg      <= req_wr_reg;
          wr_reg      <= !req_wr_reg;
          data_oe_reg <= req_wr_reg;
          state_reg   <= T2;
        end
        T2: begin
          state_reg <= T3;
        end
        T3, TW: begin
          if (bus.READY) begin
            rd_reg        <= 1'b1;
            wr_reg        <= 1'b1;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= req_miss_reg;
            if (!req_wr_reg)
              rsp_rdata_reg <= req_miss_reg ? {DATA_WIDTH{1'b1}} : DATA;
            state_reg <= T4;
          end else begin
            state_reg <= TW;
          end
        end
        T4: begin
          cs_mem_reg  <= 1'b0;
          cs_io_reg   <= 1'b0;
          data_oe_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign DATA = data_oe_reg ? wdata_reg : {DATA_WIDTH{1'bz}};

  assign bus.REQ_READY = (state_reg == IDLE) && !RESET;
  assign bus.RSP_VALID = rsp_valid_reg;
  assign bus.RSP_RDATA = rsp_rdata_reg;
  assign bus.RSP_ERR   = rsp_err_reg;
  assign bus.ALE       = ale_reg;
  assign bus.CS_MEM    = cs_mem_reg;
  assign bus.CS_IO     = cs_io_reg;
  assign bus.RD        = rd_reg;
  assign bus.WR        = wr_reg;
  assign bus.ADDRESS   = address_reg;

endmodule
